// File: rtl/mod_counter_pkg.sv
// Shared definitions for the counter library: timer state encodings and the
// load-value clamp used wherever a programmable limit is loaded.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } timer_state_t;

  // Saturate a requested value at the counter's inclusive maximum.
  function automatic int unsigned clamp_to_final(input int unsigned value,
                                                 input int unsigned max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/down_count_core.sv
// Datapath of the down timer: the count register, its reload register and
// the zero flag. Sequencing is left entirely to the instantiating FSM.
module down_count_core
  import mod_counter_pkg::*;
#(
  parameter int FINAL_VALUE = 9,
  parameter int BITS        = $clog2(FINAL_VALUE + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            dec,
  input  logic            reload,
  input  logic            load_en,
  input  logic [BITS-1:0] load_val,
  output logic [BITS-1:0] q,
  output logic            zero
);

  logic [BITS-1:0] reload_reg;

  // load_val arrives already clamped; load has priority over reload and dec.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q          <= BITS'(FINAL_VALUE);
      reload_reg <= BITS'(FINAL_VALUE);
    end else if (load_en) begin
      q          <= load_val;
      reload_reg <= load_val;
    end else if (reload) begin
      q <= reload_reg;
    end else if (dec) begin
      q <= q - BITS'(1);
    end
  end

  assign zero = (q == '0);

endmodule

// File: rtl/mod_down_timer.sv
// Programmable modulo down-counter/timer: counts a reload value down to zero
// on enable beats, pulses tc after the zero-beat, then stops or reloads.
module mod_down_timer
  import mod_counter_pkg::*;
#(
  parameter int FINAL_VALUE = 9,
  parameter int BITS        = $clog2(FINAL_VALUE + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            load,
  input  logic [BITS-1:0] load_value,
  input  logic            start,
  input  logic            stop,
  input  logic            periodic,
  output logic [BITS-1:0] Q,
  output logic            tc,
  output logic            busy,
  output logic            expired
);

  timer_state_t    state_q, state_d;
  logic            dec, reload, zero, tc_d;
  logic [BITS-1:0] clamped_value;

  assign clamped_value = BITS'(clamp_to_final(32'(load_value), FINAL_VALUE));

  down_count_core #(
    .FINAL_VALUE(FINAL_VALUE),
    .BITS       (BITS)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .dec     (dec),
    .reload  (reload),
    .load_en (load),
    .load_val(clamped_value),
    .q       (Q),
    .zero    (zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tc      <= 1'b0;
    end else begin
      state_q <= state_d;
      tc      <= tc_d;
    end
  end

  // Priority: load > stop > start > count. A zero-beat never decrements.
  always_comb begin
    state_d = state_q;
    dec     = 1'b0;
    reload  = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (enable) begin
            if (!zero) begin
              dec = 1'b1;
            end else begin
              tc_d = 1'b1;
              if (periodic) reload = 1'b1;
              else          state_d = EXPIRED;
            end
          end
        end
        IDLE, EXPIRED: begin
          if (start) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy    = (state_q == RUN);
  assign expired = (state_q == EXPIRED);

endmodule

// File: tb/tb_mod_down_timer.sv
// Directed self-checking bench for mod_down_timer with FINAL_VALUE=9, BITS=4.
module tb_mod_down_timer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_value = 4'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic [3:0] Q;
  logic       tc, busy, expired;

  int tests_run = 0;
  int tests_failed = 0;

  mod_down_timer #(.FINAL_VALUE(9), .BITS(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .load      (load),
    .load_value(load_value),
    .start     (start),
    .stop      (stop),
    .periodic  (periodic),
    .Q         (Q),
    .tc        (tc),
    .busy      (busy),
    .expired   (expired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] exp_q, input logic exp_tc,
                          input logic exp_busy, input logic exp_expired);
    checkOutput({tag, ".Q"},       32'(Q),       32'(exp_q));
    checkOutput({tag, ".tc"},      32'(tc),      32'(exp_tc));
    checkOutput({tag, ".busy"},    32'(busy),    32'(exp_busy));
    checkOutput({tag, ".expired"}, 32'(expired), 32'(exp_expired));
  endtask

  // Drive one cycle's inputs, let one rising edge pass, then settle 1 time unit.
  task automatic applyStimulus(input logic ld, input logic [3:0] lv, input logic st,
                               input logic sp, input logic en, input logic per);
    load = ld; load_value = lv; start = st; stop = sp; enable = en; periodic = per;
    @(posedge clk);
    #1;
  endtask

  // Periodic run from a known count with reload value rv: each enable beat
  // either decrements or, from zero, reloads and flags tc on the next cycle.
  task automatic runPeriodic(input string tag, input int beats, input logic [3:0] start_q,
                             input logic [3:0] rv);
    logic [3:0] exp_q;
    logic       exp_tc;
    exp_q = start_q;
    for (int i = 0; i < beats; i++) begin
      if (exp_q == 4'd0) begin
        exp_q  = rv;
        exp_tc = 1'b1;
      end else begin
        exp_q  = exp_q - 4'd1;
        exp_tc = 1'b0;
      end
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkAll($sformatf("%s[%0d]", tag, i), exp_q, exp_tc, 1'b1, 1'b0);
    end
  endtask

  initial begin
    // 1: reset values, then asynchronous reset between edges
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("reset", 4'd9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("load5", 4'd5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkAll("start_hold", 4'd5, 1'b0, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 checkAll("async_reset", 4'd9, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: one-shot from 9 down to 0, then tc pulse and EXPIRED
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkAll("oneshot_start", 4'd9, 1'b0, 1'b1, 1'b0);
    for (int i = 8; i >= 0; i--) begin
      applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkAll($sformatf("oneshot_q%0d", i), 4'(i), 1'b0, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("oneshot_tc", 4'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("oneshot_after", 4'd0, 1'b0, 1'b0, 1'b1);

    // 3: periodic with reload 3 -> period of 4 beats
    applyStimulus(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("load3", 4'd3, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkAll("per3_start", 4'd3, 1'b0, 1'b1, 1'b0);
    runPeriodic("per3", 12, 4'd3, 4'd3);

    // 4: clamped load, load beats start; reload register proven to hold 9
    applyStimulus(1'b1, 4'd15, 1'b1, 1'b0, 1'b1, 1'b1);
    checkAll("clamp15", 4'd9, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkAll("clamp_start", 4'd9, 1'b0, 1'b1, 1'b0);
    runPeriodic("per9", 11, 4'd9, 4'd9);
    applyStimulus(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkAll("zero_start", 4'd0, 1'b0, 1'b1, 1'b0);
    runPeriodic("per0", 3, 4'd0, 4'd0);

    // 5: enable gating, then stop+start together in RUN
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkAll("gate_start", 4'd6, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("gate_en1a", 4'd5, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("gate_en0a", 4'd5, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("gate_en1b", 4'd4, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkAll("gate_en0b", 4'd4, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkAll("stop_start", 4'd4, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkAll("idle_hold", 4'd4, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-run in periodic mode at Q=4, reload restored to 9
    applyStimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    runPeriodic("pre_reset", 2, 4'd6, 4'd6);
    checkOutput("mid_run_q", 32'(Q), 32'd4);
    #2 reset_n = 1'b0;
    #1 checkAll("mid_reset", 4'd9, 1'b0, 1'b0, 1'b0);
    #1 reset_n = 1'b1;
    applyStimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    checkAll("post_reset_start", 4'd9, 1'b0, 1'b1, 1'b0);
    runPeriodic("post_reset", 11, 4'd9, 4'd9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
